// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared FSM state type, default width and index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  localparam int c_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index n positions; never less than one.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_1b.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_1b
// Description : Single-bit full adder used by the serial datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/serial_adder_4b.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_4b
// Description : Bit-serial adder, LSB first, valid/ready on both sides.
//               Define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_4b
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = c_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int               c_IDX_W = clog2(WIDTH);
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(WIDTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_c;
  logic [c_IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]     r_s;
  logic                 r_cout;
  logic                 w_sum;
  logic                 w_carry;
  logic                 w_in_hs;
`ifdef SERIAL_ADDER_OVF_EN
  logic                 r_ovf;
`endif

  assign w_in_hs = in_valid && in_ready;

  full_adder_1b u_fa (
    .a    (r_a[r_idx]),
    .b    (r_b[r_idx]),
    .cin  (r_c),
    .s    (w_sum),
    .cout (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = ADD;
      ADD:     if (r_idx == c_LAST) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it stays low for the whole reset window.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = rst_n;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_idx  <= '0;
      r_s    <= '0;
      r_cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_in_hs) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= cin0;
            r_idx <= '0;
            r_s   <= '0;
          end
        end
        ADD: begin
          r_s[r_idx] <= w_sum;
          r_c        <= w_carry;
          r_idx      <= r_idx + c_IDX_W'(1);
          if (r_idx == c_LAST) begin
            r_cout <= w_carry;
`ifdef SERIAL_ADDER_OVF_EN
            // r_c here is the carry into the MSB.
            r_ovf  <= r_c ^ w_carry;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule
`default_nettype wire
